caesar_cg_ctrl: RTL
===================

CAESAR_CG_CTRL -- requirements
Module: caesar_cg_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the idle counter and of idle_thresh_i.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2, legal range 1..255: clock-settle cycles held in WAKE before grants resume.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, ungated.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req_i, input, 1 bit: OBI-style request to caesar; master holds it high until gnt_o.
REQ-006 SHALL have port gnt_o, output, 1 bit: grant back to the bus master.
REQ-007 SHALL have port busy_i, input, 1 bit: caesar internal computation in progress.
REQ-008 SHALL have port force_on_i, input, 1 bit: software override that keeps the clock running.
REQ-009 SHALL have port idle_thresh_i, input, CNT_W bits: consecutive idle cycles before gating; 0 disables gating.
REQ-010 SHALL have port cg_en_o, output, 1 bit: enable to the caesar clock-gating cell.
REQ-011 SHALL have port gated_o, output, 1 bit: status, high while the caesar clock is off.

Function
REQ-012 SHALL implement FSM states ON, COUNT, OFF, WAKE in a registered state register.
REQ-013 SHALL define idle as the condition !req_i && !busy_i && !force_on_i && idle_thresh_i != 0.
REQ-014 ON: idle -> COUNT with counter=1; otherwise stay ON with counter=0.
REQ-015 COUNT: not idle -> ON with counter=0; idle && counter >= idle_thresh_i -> OFF; otherwise counter+1, saturating at 2^CNT_W-1.
REQ-016 OFF: req_i || force_on_i -> WAKE with counter=1; otherwise stay OFF; busy_i is ignored in OFF.
REQ-017 WAKE: when counter == WAKE_CYCLES -> ON with counter=0; otherwise counter+1; no exit to OFF from WAKE.
REQ-018 cg_en_o SHALL be a pure decode of the state register: 0 in OFF only, 1 in ON, COUNT and WAKE; no combinational path from inputs.
REQ-019 gated_o SHALL equal (state == OFF).
REQ-020 gnt_o SHALL equal req_i && (state == ON || state == COUNT), combinationally.
REQ-021 gnt_o SHALL be 0 in OFF and WAKE; requests stall there until ON.
REQ-022 Latency: req_i rising in OFF at edge t gives cg_en_o=1 after edge t+1 and gnt_o=1 after edge t+1+WAKE_CYCLES, provided req_i is held.
REQ-023 Gating latency: with continuous idle from ON, OFF is entered exactly idle_thresh_i+1 edges after idle first holds; idle_thresh_i=1 gives 2 edges.
REQ-024 Lowering idle_thresh_i below the counter during COUNT SHALL cause OFF on the next edge if still idle.
REQ-025 Setting idle_thresh_i=0 during COUNT SHALL return the FSM to ON; in OFF it SHALL have no effect until a wake event.
REQ-026 A request arriving in the same cycle that COUNT would reach threshold SHALL go to ON (activity wins); gnt_o is asserted that cycle.
REQ-027 force_on_i SHALL behave as activity in every state: it wakes OFF and blocks gating.

Reset
REQ-028 While rst_i is high, outputs SHALL be: state=ON, counter=0, cg_en_o=1, gated_o=0, gnt_o=req_i (ON decode).
REQ-029 Reset SHALL start in ON so caesar's synchronous reset logic sees clock edges.
REQ-030 Reset asserted in OFF or WAKE SHALL immediately (asynchronously) force ON and cg_en_o=1.

Verification
REQ-031 idle_thresh_i=4, req_i=busy_i=force_on_i=0 from reset release -> cg_en_o falls after edge 5; gated_o=1.
REQ-032 In OFF, WAKE_CYCLES=2, req_i raised and held -> cg_en_o=1 after 1 edge, gnt_o=1 after 3 edges, exactly one grant when req_i drops.
REQ-033 idle_thresh_i=4, busy_i pulse at COUNT counter=3 -> back to ON, counter=0; OFF is reached only 5 edges after busy_i falls.
REQ-034 force_on_i=1 with idle_thresh_i=1 for 100 cycles -> cg_en_o stays 1; force_on_i raised in OFF -> WAKE then ON, gnt_o=0 throughout.
REQ-035 rst_i pulsed mid-WAKE (counter=1) -> cg_en_o=1 and state ON asynchronously; after release, normal counting restarts from 0.
REQ-036 Idle with idle_thresh_i=10, changed to 2 at counter=6 -> OFF on the next edge.

Source files
------------

// File: rtl/caesar_cg_ctrl.sv
// caesar_cg_ctrl: idle-driven clock-gating controller for the caesar block.
// Counts consecutive idle cycles and drops the gating-cell enable once the
// programmed threshold is reached. On a request or a force, it restores the
// clock and waits for it to settle before granting bus requests again.
// CNT_W must be wide enough to hold WAKE_CYCLES.
module caesar_cg_ctrl #(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             busy_i,
    input  logic             force_on_i,
    input  logic [CNT_W-1:0] idle_thresh_i,
    output logic             cg_en_o,
    output logic             gated_o
);

    typedef enum logic [1:0] {ON, COUNT, OFF, WAKE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             idle;
    logic             wake_ev;

    // A zero threshold disables gating, so it never counts as idle.
    assign idle    = !req_i && !busy_i && !force_on_i && (idle_thresh_i != '0);
    // busy_i is deliberately not a wake source: with the clock off, caesar cannot be busy.
    assign wake_ev = req_i || force_on_i;

    // State register and shared idle/settle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ON;
            cnt   <= '0;
        end else begin
            case (state)
                ON: begin
                    if (idle) begin
                        state <= COUNT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                COUNT: begin
                    // Activity (including a request at threshold) always wins.
                    if (!idle) begin
                        state <= ON;
                        cnt   <= '0;
                    end else if (cnt >= idle_thresh_i) begin
                        state <= OFF;
                        cnt   <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                OFF: begin
                    if (wake_ev) begin
                        state <= WAKE;
                        cnt   <= CNT_ONE;
                    end
                end
                WAKE: begin
                    // Settle period runs to completion; there is no path back to OFF.
                    if (cnt == WAKE_LAST) begin
                        state <= ON;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ON;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Enables are pure state decodes, so the gating cell never sees an input glitch.
    assign cg_en_o = (state != OFF);
    assign gated_o = (state == OFF);
    assign gnt_o   = req_i && ((state == ON) || (state == COUNT));

endmodule
